// File: rtl/half_word_serializer_if.sv
// Narrow store link: 32-bit words in, 16-bit half-word beats out.
// master drives words and beat acceptance; slave is the serializer.
interface half_word_serializer_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_word;
   logic        in_sext;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_half;
   logic        out_last;
   logic        out_short;

   modport master (
      output in_valid,
      output in_word,
      output in_sext,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_half,
      input  out_last,
      input  out_short
   );

   modport slave (
      input  in_valid,
      input  in_word,
      input  in_sext,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_half,
      output out_last,
      output out_short
   );
endinterface

// File: rtl/half_word_serializer.sv
// Splits 32-bit store words into low/high 16-bit beats; extension-redundant
// words go out as a single short beat that the receiver re-widens.
module half_word_serializer #(
   parameter bit COMPRESS = 1'b1
) (
   input  logic                         clk,
   input  logic                         reset,
   half_word_serializer_if.slave        bus,
   output logic                         busy,
   output logic [15:0]                  word_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND_LO = 2'd1,
      SEND_HI = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] hi_hold_q, hi_hold_d;
   logic [15:0] out_half_q, out_half_d;
   logic [15:0] word_count_q, word_count_d;
   logic        out_valid_q, out_valid_d;
   logic        out_last_q, out_last_d;
   logic        out_short_q, out_short_d;

   logic        in_ready;
   logic        in_fire;
   logic        out_fire;
   logic        compress;

   assign out_fire = out_valid_q && bus.out_ready;

   // Final-beat cycles also accept, so words stream with no bubble.
   assign in_ready = !reset &&
                     ((state_q == IDLE) || (out_fire && out_last_q));
   assign in_fire  = bus.in_valid && in_ready;

   assign compress = COMPRESS &&
                     (bus.in_word[31:16] ==
                      {16{bus.in_sext & bus.in_word[15]}});

   always_comb begin
      state_d      = state_q;
      hi_hold_d    = hi_hold_q;
      out_half_d   = out_half_q;
      word_count_d = word_count_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      out_short_d  = out_short_q;

      if (out_fire) begin
         if (out_last_q) begin
            word_count_d = word_count_q + 16'd1;
            state_d      = IDLE;
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            out_short_d  = 1'b0;
         end else begin
            state_d      = SEND_HI;
            out_half_d   = hi_hold_q;
            out_last_d   = 1'b1;
            out_short_d  = 1'b0;
         end
      end

      // Acceptance only happens from IDLE or a final beat, so it wins.
      if (in_fire) begin
         hi_hold_d   = bus.in_word[31:16];
         out_half_d  = bus.in_word[15:0];
         out_valid_d = 1'b1;
         state_d     = SEND_LO;
         out_last_d  = compress;
         out_short_d = compress;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         hi_hold_q    <= 16'h0000;
         out_half_q   <= 16'h0000;
         word_count_q <= 16'h0000;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_short_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         hi_hold_q    <= hi_hold_d;
         out_half_q   <= out_half_d;
         word_count_q <= word_count_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         out_short_q  <= out_short_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_half  = out_half_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_short = out_short_q;
   assign busy          = (state_q != IDLE);
   assign word_count    = word_count_q;

endmodule

// File: tb/tb_half_word_serializer.sv
// Directed bench for half_word_serializer: two instances,
// COMPRESS=1 (dut0) and COMPRESS=0 (dut1).
module tb_half_word_serializer;

   logic        clk = 1'b0;
   logic        reset;
   logic        busy0, busy1;
   logic [15:0] wc0, wc1;
   int          checks = 0;
   int          failures = 0;

   half_word_serializer_if if0 ();
   half_word_serializer_if if1 ();

   half_word_serializer #(.COMPRESS(1'b1)) dut0 (
      .clk        (clk),
      .reset      (reset),
      .bus        (if0.slave),
      .busy       (busy0),
      .word_count (wc0)
   );

   half_word_serializer #(.COMPRESS(1'b0)) dut1 (
      .clk        (clk),
      .reset      (reset),
      .bus        (if1.slave),
      .busy       (busy1),
      .word_count (wc1)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // {out_valid, out_last, out_short, out_half}
   function automatic logic [18:0] obs(bit sel);
      if (sel)
         return {if1.out_valid, if1.out_last, if1.out_short, if1.out_half};
      return {if0.out_valid, if0.out_last, if0.out_short, if0.out_half};
   endfunction

   function automatic logic rdy(bit sel);
      return sel ? if1.in_ready : if0.in_ready;
   endfunction

   task automatic drive(bit sel, logic v, logic [31:0] w, logic s, logic r);
      if (sel) begin
         if1.in_valid = v; if1.in_word = w;
         if1.in_sext = s;  if1.out_ready = r;
      end else begin
         if0.in_valid = v; if0.in_word = w;
         if0.in_sext = s;  if0.out_ready = r;
      end
   endtask

   // One word from idle with out_ready held high; nb = expected beats.
   task automatic send(bit sel, string tag, logic [31:0] w, logic s,
                       int nb, logic [15:0] b0, logic [15:0] b1);
      @(negedge clk);
      drive(sel, 1'b1, w, s, 1'b1);
      check({tag, "_rdy"}, 32'(rdy(sel)), 32'd1);
      @(negedge clk);
      drive(sel, 1'b0, 32'h0, 1'b0, 1'b1);
      check({tag, "_b0"}, 32'(obs(sel)),
            32'({1'b1, nb == 1, nb == 1, b0}));
      if (nb == 2) begin
         @(negedge clk);
         check({tag, "_b1"}, 32'(obs(sel)), 32'({3'b110, b1}));
      end
      @(negedge clk);
      check({tag, "_end"}, 32'(obs(sel)),
            32'({3'b000, (nb == 2) ? b1 : b0}));
   endtask

   logic [31:0] sw [3];
   logic [15:0] sb [6];

   initial begin
      sw[0] = 32'hA1A2_B1B2;
      sw[1] = 32'hC1C2_D1D2;
      sw[2] = 32'hE1E2_F1F2;
      sb[0] = 16'hB1B2; sb[1] = 16'hA1A2;
      sb[2] = 16'hD1D2; sb[3] = 16'hC1C2;
      sb[4] = 16'hF1F2; sb[5] = 16'hE1E2;

      reset = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      check("rst_obs", 32'(obs(1'b0)), 32'h0);
      check("rst_busy", 32'(busy0), 32'h0);
      check("rst_wc", 32'(wc0), 32'h0);
      check("rst_rdy", 32'(rdy(1'b0)), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("idle_rdy", 32'(rdy(1'b0)), 32'h1);

      send(1'b0, "full", 32'h1234_5678, 1'b0, 2, 16'h5678, 16'h1234);
      check("full_wc", 32'(wc0), 32'd1);

      send(1'b0, "zext", 32'h0000_7FFF, 1'b0, 1, 16'h7FFF, 16'h0000);
      send(1'b1, "nocmp", 32'h0000_7FFF, 1'b0, 2, 16'h7FFF, 16'h0000);
      check("nocmp_wc", 32'(wc1), 32'd1);
      send(1'b0, "sext", 32'hFFFF_8000, 1'b1, 1, 16'h8000, 16'h0000);
      send(1'b0, "sx_z", 32'hFFFF_8000, 1'b0, 2, 16'h8000, 16'hFFFF);
      send(1'b0, "sx_pos", 32'h0000_8000, 1'b1, 2, 16'h8000, 16'h0000);
      check("cmp_wc", 32'(wc0), 32'd5);

      // Backpressure on the low beat.
      @(negedge clk);
      drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("bp_hold", 32'(obs(1'b0)), 32'({3'b100, 16'hBEEF}));
         check("bp_rdy", 32'(rdy(1'b0)), 32'h0);
         @(negedge clk);
      end
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      check("bp_hi", 32'(obs(1'b0)), 32'({3'b110, 16'hDEAD}));
      @(negedge clk);
      check("bp_end", 32'(obs(1'b0)), 32'({3'b000, 16'hDEAD}));

      // Back-to-back stream of three full words.
      drive(1'b0, 1'b1, sw[0], 1'b0, 1'b1);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         check("st_beat", 32'(obs(1'b0)),
               32'({1'b1, i % 2 == 0, 1'b0, sb[i-1]}));
         check("st_rdy", 32'(rdy(1'b0)), 32'(i % 2 == 0));
         if (i == 1) drive(1'b0, 1'b1, sw[1], 1'b0, 1'b1);
         if (i == 3) drive(1'b0, 1'b1, sw[2], 1'b0, 1'b1);
         if (i == 5) drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      end
      @(negedge clk);
      check("st_end", 32'(obs(1'b0)), 32'({3'b000, 16'hE1E2}));
      check("st_wc", 32'(wc0), 32'd9);

      // Reset in the middle of a stalled word.
      drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("mr_pre", 32'(obs(1'b0)), 32'({3'b100, 16'hBEEF}));
      #2 reset = 1'b1;
      #1;
      check("mr_obs", 32'(obs(1'b0)), 32'h0);
      check("mr_busy", 32'(busy0), 32'h0);
      check("mr_wc", 32'(wc0), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      send(1'b0, "mr_new", 32'h1234_5678, 1'b0, 2, 16'h5678, 16'h1234);
      check("mr_wc1", 32'(wc0), 32'd1);

      // Counter wrap: 65534 more short words reach 16'hFFFF.
      drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
      repeat (65534) @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      check("wrap_ffff", 32'(wc0), 32'h0000_FFFF);
      check("wrap_busy", 32'(busy0), 32'h0);
      send(1'b0, "wrap", 32'h0, 1'b0, 1, 16'h0000, 16'h0000);
      check("wrap_zero", 32'(wc0), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/half_word_serializer.md
Name: half_word_serializer

Overview:
- Store-side counterpart to the immediate extender: takes 32-bit words and emits them as 16-bit halves over a narrow valid/ready link.
- A word whose upper half is only the zero- or sign-extension of its lower half goes out as a single "short" beat. The receiving end re-widens it with the extender.
- Sits between the datapath write port and the 16-bit memory/peripheral bus.

Parameters:
- COMPRESS, 1, 1 enables single-beat transfer of extension-redundant words; 0 always sends two beats.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_word/in_sext valid.
- in_ready  output  1  block can accept a word this cycle.
- in_word  input  32  word to serialize.
- in_sext  input  1  1 means compressibility is checked against sign extension; 0 means against zero extension.
- out_valid  output  1  out_half valid.
- out_ready  input  1  downstream accepts the beat this cycle.
- out_half  output  16  current half-word beat.
- out_last  output  1  final beat of the current word.
- out_short  output  1  word is compressed (single beat).
- busy  output  1  a word is held and not yet fully sent.
- word_count  output  16  number of completed words; wraps.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset (asserts immediately, no clock needed):
  - state = IDLE.
  - out_valid, out_last, out_short, busy = 0.
  - out_half = 16'h0000; word_count = 16'h0000.
  - in_ready is forced 0 while reset is high.
- States: IDLE, SEND_LO, SEND_HI.
- Handshakes: a transfer happens on a rising edge where valid && ready.
- in_ready:
  - Combinational: (state == IDLE) || (out_valid && out_ready && out_last).
  - This allows back-to-back words with no bubble.
- Word acceptance (in transfer):
  - Register in_word[31:16] as hi_hold.
  - Drive out_half = in_word[15:0] and out_valid = 1 from the next cycle.
  - Compressible when COMPRESS == 1 and in_word[31:16] == {16{in_sext & in_word[15]}}.
  - Compressible word: state → SEND_LO, out_last = 1, out_short = 1.
  - Otherwise: state → SEND_LO, out_last = 0, out_short = 0.
- SEND_LO, out transfer, out_last == 0:
  - State → SEND_HI; out_half = hi_hold, out_last = 1, out_short = 0.
- Final-beat transfer (out_last == 1, either state):
  - word_count increments by 1 (16'hFFFF → 16'h0000).
  - If an in transfer happens in the same cycle, load the new word as above.
  - Otherwise: state → IDLE, out_valid = 0, out_last = 0, out_short = 0. out_half keeps its last value.
- Backpressure: while out_valid && !out_ready, out_half, out_last, out_short and state hold stable.
- Output registers: out_valid, out_half, out_last and out_short are registered; no combinational in→out path.
- busy = (state != IDLE).
- Latency: first beat appears 1 cycle after acceptance.
  - Full word: 2 beats, 2 cycles minimum.
  - Short word: 1 beat, 1 cycle minimum.
- Beat order is always low half first, then high half.
- in_sext is only sampled at acceptance. in_valid without in_ready has no effect, and in_word may change freely then.
- Reset mid-word: the partial word is discarded and word_count is not incremented; after reset, the next accepted word starts from SEND_LO.

Test Plan:
- Reset mid-transfer: accept 32'hDEAD_BEEF, deassert out_ready, pulse reset → out_valid = 0, busy = 0, word_count = 0 asynchronously; next word 32'h1234_5678 emits 16'h5678 then 16'h1234.
- Full word, out_ready = 1: in_word 32'h1234_5678, in_sext = 0 → beats 16'h5678 (last 0), then 16'h1234 (last 1), short = 0 on both; word_count = 1.
- Zero-extended compression: 32'h0000_7FFF, in_sext = 0 → single beat 16'h7FFF, last = 1, short = 1. Same word with COMPRESS = 0 → two beats: 16'h7FFF, then 16'h0000.
- Sign-extended compression:
  - 32'hFFFF_8000, in_sext = 1 → single short beat 16'h8000.
  - 32'hFFFF_8000, in_sext = 0 → two beats.
  - 32'h0000_8000, in_sext = 1 → two beats.
- Backpressure and back-to-back:
  - Hold out_ready = 0 for 3 cycles on beat 16'hBEEF of 32'hDEAD_BEEF → out_half stays 16'hBEEF.
  - Then stream 3 full words with in_valid = 1 and out_ready = 1 → 6 consecutive beats, no idle cycle; in_ready is high only on IDLE or final-beat cycles.
- Counter wrap: preload by sending 65535 short words (32'h0), then 1 more → word_count 16'hFFFF → 16'h0000.
